manycore_mesh_router_node: RTL and testbench

// - 5-port dimension-ordered mesh router node for the manycore network.
// - One instance sits at each mesh position; the manycore IO row uses it directly, and tiles embed it.
// - Ports P(processor)=0, W=1, E=2, N=3, S=4; neighbours are stitched W<->E and N<->S.
// - Each input has a 2-entry FIFO; each output has a round-robin arbiter and a valid/ready handshake.

---
 rtl/manycore_mesh_router_node.sv | 134 +++++++++++++
 tb/tb_manycore_mesh_router_node.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manycore_mesh_router_node.sv
// 5-port (P,W,E,N,S) mesh router node: 2-entry input FIFOs, dimension-ordered routing, round-robin output arbiters.
// Define MESH_NODE_YX_ROUTING_EN to route Y first; the default build routes X first.
module manycore_mesh_router_node #(
   parameter int x_cord_width_p = 4,
   parameter int y_cord_width_p = 3,
   parameter int addr_width_p   = 20,
   parameter int data_width_p   = 32,
   localparam int pkt_w = data_width_p + addr_width_p + y_cord_width_p + x_cord_width_p
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [x_cord_width_p-1:0] my_x_i,
   input  logic [y_cord_width_p-1:0] my_y_i,
   input  logic [4:0]                v_i,
   input  logic [5*pkt_w-1:0]        data_i,
   output logic [4:0]                ready_o,
   output logic [4:0]                v_o,
   output logic [5*pkt_w-1:0]        data_o,
   input  logic [4:0]                ready_i
);

   localparam logic [2:0] port_p = 3'd0;
   localparam logic [2:0] port_w = 3'd1;
   localparam logic [2:0] port_e = 3'd2;
   localparam logic [2:0] port_n = 3'd3;
   localparam logic [2:0] port_s = 3'd4;

   logic [pkt_w-1:0]          mem [5][2];
   logic [4:0]                wr_ptr, rd_ptr;
   logic [1:0]                cnt [5];
   logic [4:0]                full, empty, enq, deq;
   logic [pkt_w-1:0]          head [5];
   logic [x_cord_width_p-1:0] hx [5];
   logic [y_cord_width_p-1:0] hy [5];
   logic [2:0]                route [5];

   logic [4:0]                req [5];
   logic [2:0]                grant [5];
   logic [2:0]                ptr [5];
   logic [4:0]                held;
   logic [2:0]                held_idx [5];

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         head[k]  = mem[k][rd_ptr[k]];
         hx[k]    = head[k][x_cord_width_p-1:0];
         hy[k]    = head[k][x_cord_width_p +: y_cord_width_p];
         full[k]  = (cnt[k] == 2'd2);
         empty[k] = (cnt[k] == 2'd0);
         enq[k]   = v_i[k] & ~full[k];
      end
   end

   assign ready_o = reset_i ? 5'b00000 : ~full;

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         route[k] = port_p;
`ifdef MESH_NODE_YX_ROUTING_EN
         if (hy[k] < my_y_i)      route[k] = port_n;
         else if (hy[k] > my_y_i) route[k] = port_s;
         else if (hx[k] < my_x_i) route[k] = port_w;
         else if (hx[k] > my_x_i) route[k] = port_e;
`else
         if (hx[k] < my_x_i)      route[k] = port_w;
         else if (hx[k] > my_x_i) route[k] = port_e;
         else if (hy[k] < my_y_i) route[k] = port_n;
         else if (hy[k] > my_y_i) route[k] = port_s;
`endif
      end
   end

   // Descending scan so the requestor closest at/after ptr wins; a stalled output keeps its grant.
   always_comb begin
      v_o    = '0;
      data_o = '0;
      deq    = '0;
      for (int o = 0; o < 5; o++) begin
         grant[o] = '0;
         for (int k = 0; k < 5; k++)
            req[o][k] = ~empty[k] & (route[k] == 3'(o));
         for (int i = 4; i >= 0; i--)
            if (req[o][(int'(ptr[o]) + i) % 5])
               grant[o] = 3'((int'(ptr[o]) + i) % 5);
         if (held[o])
            grant[o] = held_idx[o];
         v_o[o] = |req[o];
         if (v_o[o])
            data_o[o*pkt_w +: pkt_w] = head[grant[o]];
         for (int k = 0; k < 5; k++)
            if (v_o[o] && ready_i[o] && grant[o] == 3'(k))
               deq[k] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 5; k++)
         if (enq[k])
            mem[k][wr_ptr[k]] <= data_i[k*pkt_w +: pkt_w];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         held   <= '0;
         for (int k = 0; k < 5; k++) begin
            cnt[k]      <= 2'd0;
            ptr[k]      <= port_p;
            held_idx[k] <= port_p;
         end
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (enq[k]) wr_ptr[k] <= ~wr_ptr[k];
            if (deq[k]) rd_ptr[k] <= ~rd_ptr[k];
            case ({enq[k], deq[k]})
               2'b10:   cnt[k] <= cnt[k] + 2'd1;
               2'b01:   cnt[k] <= cnt[k] - 2'd1;
               default: cnt[k] <= cnt[k];
            endcase
         end
         for (int o = 0; o < 5; o++) begin
            if (v_o[o] && ready_i[o]) begin
               ptr[o]  <= (grant[o] == 3'd4) ? 3'd0 : grant[o] + 3'd1;
               held[o] <= 1'b0;
            end else if (v_o[o]) begin
               held[o]     <= 1'b1;
               held_idx[o] <= grant[o];
            end
         end
      end
   end

endmodule

// File: tb/tb_manycore_mesh_router_node.sv
// Self-checking bench for manycore_mesh_router_node: directed scenarios plus a randomized run against a queue model.
module tb_manycore_mesh_router_node;

   localparam int XW = 4;
   localparam int YW = 3;
   localparam int AW = 20;
   localparam int DW = 32;
   localparam int PW = DW + AW + YW + XW;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic [XW-1:0] my_x_i = '0;
   logic [YW-1:0] my_y_i = '0;
   logic [4:0]    v_i = '0;
   logic [5*PW-1:0] data_i = '0;
   logic [4:0]    ready_o;
   logic [4:0]    v_o;
   logic [5*PW-1:0] data_o;
   logic [4:0]    ready_i = '1;

   int n_cmp = 0;
   int n_err = 0;

   manycore_mesh_router_node #(
      .x_cord_width_p(XW), .y_cord_width_p(YW),
      .addr_width_p(AW), .data_width_p(DW)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
      .v_i(v_i), .data_i(data_i), .ready_o(ready_o), .v_o(v_o),
      .data_o(data_o), .ready_i(ready_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [PW-1:0] mk_pkt(int x, int y);
      logic [DW-1:0] d = $urandom;
      logic [AW-1:0] a = AW'($urandom);
      return {d, a, YW'(y), XW'(x)};
   endfunction

   function automatic int exp_port(logic [PW-1:0] p, int mx, int my);
      int dx = int'(p[XW-1:0]);
      int dy = int'(p[XW +: YW]);
`ifdef MESH_NODE_YX_ROUTING_EN
      if (dy < my) return 3;
      if (dy > my) return 4;
      if (dx < mx) return 1;
      if (dx > mx) return 2;
`else
      if (dx < mx) return 1;
      if (dx > mx) return 2;
      if (dy < my) return 3;
      if (dy > my) return 4;
`endif
      return 0;
   endfunction

   task automatic do_reset(int mx, int my);
      reset_i = 1'b1;
      v_i     = '0;
      data_i  = '0;
      ready_i = '1;
      my_x_i  = XW'(mx);
      my_y_i  = YW'(my);
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      #1;
      n_cmp++;
      if (ready_o !== 5'b00000) begin n_err++; $display("FAIL reset_ready_o: got %b want 00000", ready_o); end
      n_cmp++;
      if (v_o !== 5'b00000 || data_o !== '0) begin n_err++; $display("FAIL reset_v_o: got v=%b want 00000 with zero data", v_o); end
      do_reset(2, 2);
      #1;
      n_cmp++;
      if (ready_o !== 5'b11111) begin n_err++; $display("FAIL release_ready_o: got %b want 11111", ready_o); end
   endtask

   task automatic test_route_west();
      logic [PW-1:0] p;
      do_reset(2, 2);
      @(negedge clk_i);
      p = mk_pkt(0, 2);
      v_i[0] = 1'b1;
      data_i[0 +: PW] = p;
      @(negedge clk_i);
      v_i = '0;
      n_cmp++;
      if (v_o !== 5'b00010) begin n_err++; $display("FAIL route_w_valid: got %b want 00010", v_o); end
      n_cmp++;
      if (data_o[1*PW +: PW] !== p) begin n_err++; $display("FAIL route_w_data: got %h want %h", data_o[1*PW +: PW], p); end
      @(negedge clk_i);
      n_cmp++;
      if (v_o !== 5'b00000) begin n_err++; $display("FAIL route_w_drain: got %b want 00000", v_o); end
   endtask

   task automatic test_arbiter_order();
      logic [PW-1:0] pw, pn;
      do_reset(2, 2);
      @(negedge clk_i);
      pw = mk_pkt(2, 2);
      pn = mk_pkt(2, 2);
      v_i = 5'b01010;
      data_i[1*PW +: PW] = pw;
      data_i[3*PW +: PW] = pn;
      @(negedge clk_i);
      v_i = '0;
      n_cmp++;
      if (v_o !== 5'b00001 || data_o[0 +: PW] !== pw) begin n_err++; $display("FAIL arb_first: got v=%b d=%h want v=00001 d=%h", v_o, data_o[0 +: PW], pw); end
      @(negedge clk_i);
      n_cmp++;
      if (v_o !== 5'b00001 || data_o[0 +: PW] !== pn) begin n_err++; $display("FAIL arb_second: got v=%b d=%h want v=00001 d=%h", v_o, data_o[0 +: PW], pn); end
      @(negedge clk_i);
      n_cmp++;
      if (v_o !== 5'b00000) begin n_err++; $display("FAIL arb_drain: got %b want 00000", v_o); end
   endtask

   task automatic test_backpressure();
      logic [PW-1:0] p [3];
      do_reset(2, 2);
      for (int i = 0; i < 3; i++) p[i] = mk_pkt(3, 2);
      @(negedge clk_i);
      ready_i[2] = 1'b0;
      v_i[0] = 1'b1;
      data_i[0 +: PW] = p[0];
      @(negedge clk_i);
      n_cmp++;
      if (v_o[2] !== 1'b1 || data_o[2*PW +: PW] !== p[0]) begin n_err++; $display("FAIL bp_first_valid: got v=%b d=%h want 1 d=%h", v_o[2], data_o[2*PW +: PW], p[0]); end
      data_i[0 +: PW] = p[1];
      @(negedge clk_i);
      n_cmp++;
      if (ready_o[0] !== 1'b0) begin n_err++; $display("FAIL bp_full: got ready_o[P]=%b want 0", ready_o[0]); end
      data_i[0 +: PW] = p[2];
      @(negedge clk_i);
      n_cmp++;
      if (v_o[2] !== 1'b1 || data_o[2*PW +: PW] !== p[0] || ready_o[0] !== 1'b0) begin
         n_err++; $display("FAIL bp_hold: got v=%b d=%h rdy=%b want 1 d=%h rdy 0", v_o[2], data_o[2*PW +: PW], ready_o[0], p[0]);
      end
      ready_i[2] = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (v_o[2] !== 1'b1 || data_o[2*PW +: PW] !== p[1] || ready_o[0] !== 1'b1) begin
         n_err++; $display("FAIL bp_second: got v=%b d=%h rdy=%b want 1 d=%h rdy 1", v_o[2], data_o[2*PW +: PW], ready_o[0], p[1]);
      end
      @(negedge clk_i);
      v_i = '0;
      n_cmp++;
      if (v_o[2] !== 1'b1 || data_o[2*PW +: PW] !== p[2]) begin n_err++; $display("FAIL bp_third: got v=%b d=%h want 1 d=%h", v_o[2], data_o[2*PW +: PW], p[2]); end
      @(negedge clk_i);
      n_cmp++;
      if (v_o !== 5'b00000) begin n_err++; $display("FAIL bp_drain: got %b want 00000", v_o); end
   endtask

   task automatic test_parallel();
      logic [PW-1:0] pe, pw;
      do_reset(1, 1);
      @(negedge clk_i);
      pe = mk_pkt(1, 0);
      pw = mk_pkt(3, 1);
      v_i = 5'b00110;
      data_i[2*PW +: PW] = pe;
      data_i[1*PW +: PW] = pw;
      @(negedge clk_i);
      v_i = '0;
      n_cmp++;
      if (v_o !== 5'b01100) begin n_err++; $display("FAIL par_valid: got %b want 01100", v_o); end
      n_cmp++;
      if (data_o[3*PW +: PW] !== pe || data_o[2*PW +: PW] !== pw) begin
         n_err++; $display("FAIL par_data: got N=%h E=%h want N=%h E=%h", data_o[3*PW +: PW], data_o[2*PW +: PW], pe, pw);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset(2, 2);
      @(negedge clk_i);
      ready_i = '0;
      v_i[0] = 1'b1;
      data_i[0 +: PW] = mk_pkt(0, 2);
      @(negedge clk_i);
      data_i[0 +: PW] = mk_pkt(0, 2);
      @(negedge clk_i);
      v_i = '0;
      #2 reset_i = 1'b1;
      #1;
      n_cmp++;
      if (v_o !== 5'b00000 || data_o !== '0 || ready_o !== 5'b00000) begin
         n_err++; $display("FAIL midreset_async: got v=%b rdy=%b want 00000/00000 and zero data", v_o, ready_o);
      end
      @(negedge clk_i);
      ready_i = '1;
      reset_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         n_cmp++;
         if (v_o !== 5'b00000) begin n_err++; $display("FAIL midreset_stale: got %b want 00000", v_o); end
      end
   endtask

   task automatic test_routing_mode();
      logic [4:0] want;
`ifdef MESH_NODE_YX_ROUTING_EN
      want = 5'b01000;
`else
      want = 5'b00010;
`endif
      do_reset(2, 2);
      @(negedge clk_i);
      v_i[0] = 1'b1;
      data_i[0 +: PW] = mk_pkt(0, 0);
      @(negedge clk_i);
      v_i = '0;
      n_cmp++;
      if (v_o !== want) begin n_err++; $display("FAIL routing_mode: got %b want %b", v_o, want); end
   endtask

   task automatic test_random();
      logic [PW-1:0] q [5][$];
      int            rptr [5];
      bit            hld [5];
      int            hidx [5];
      int            g [5];
      logic [4:0]    ev, er;
      logic [5*PW-1:0] ed;
      do_reset(2, 2);
      for (int k = 0; k < 5; k++) begin rptr[k] = 0; hld[k] = 0; hidx[k] = 0; end
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         ev = '0; ed = '0;
         for (int o = 0; o < 5; o++) begin
            g[o] = -1;
            if (hld[o]) g[o] = hidx[o];
            else
               for (int i = 0; i < 5; i++) begin
                  int j = (rptr[o] + i) % 5;
                  if (g[o] < 0 && q[j].size() > 0 && exp_port(q[j][0], 2, 2) == o) g[o] = j;
               end
            if (g[o] >= 0) begin ev[o] = 1'b1; ed[o*PW +: PW] = q[g[o]][0]; end
         end
         for (int k = 0; k < 5; k++) er[k] = (q[k].size() < 2);
         n_cmp++;
         if (v_o !== ev) begin n_err++; $display("FAIL rand_v_o cyc %0d: got %b want %b", c, v_o, ev); end
         n_cmp++;
         if (data_o !== ed) begin n_err++; $display("FAIL rand_data_o cyc %0d: got %h want %h", c, data_o, ed); end
         n_cmp++;
         if (ready_o !== er) begin n_err++; $display("FAIL rand_ready_o cyc %0d: got %b want %b", c, ready_o, er); end
         for (int k = 0; k < 5; k++) begin
            v_i[k] = 1'($urandom_range(0, 1));
            data_i[k*PW +: PW] = mk_pkt($urandom_range(0, 4), $urandom_range(0, 4));
            ready_i[k] = ($urandom_range(0, 3) != 0);
         end
         for (int o = 0; o < 5; o++) begin
            if (ev[o] && ready_i[o]) begin
               void'(q[g[o]].pop_front());
               rptr[o] = (g[o] + 1) % 5;
               hld[o] = 0;
            end else if (ev[o]) begin
               hld[o] = 1;
               hidx[o] = g[o];
            end
         end
         for (int k = 0; k < 5; k++)
            if (v_i[k] && er[k]) q[k].push_back(data_i[k*PW +: PW]);
      end
      @(negedge clk_i);
      v_i = '0;
      ready_i = '1;
   endtask

   initial begin
      test_reset();
      test_route_west();
      test_arbiter_order();
      test_backpressure();
      test_parallel();
      test_reset_midflight();
      test_routing_mode();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
